// File: rtl/memaccess_unit_pkg.sv
// memaccess_unit_pkg: operation and FSM state types shared by the memory access unit
package memaccess_unit_pkg;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_INDIRECT, OP_NONE} mem_op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_FINISH} state_e;
    localparam int CNT_W = 16;
    localparam int LVL_W = 3;
endpackage

// File: rtl/memaccess_unit_if.sv
// memaccess_unit_if: request and memory-side handshake signals of the memory access unit
interface memaccess_unit_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
    logic              start;
    logic [1:0]        mem_state;
    logic [ADDR_W-1:0] M_Addr;
    logic [DATA_W-1:0] M_Data;
    logic [DATA_W-1:0] DMem_dout;
    logic              dmem_ack;
    logic              dmem_en;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_din;
    logic [DATA_W-1:0] memout;
    logic              busy;
    logic              done;
    logic              err;
    modport slave (
        input  start, mem_state, M_Addr, M_Data, DMem_dout, dmem_ack,
        output dmem_en, dmem_we, dmem_addr, dmem_din, memout, busy, done, err
    );
    modport master (
        output start, mem_state, M_Addr, M_Data, DMem_dout, dmem_ack,
        input  dmem_en, dmem_we, dmem_addr, dmem_din, memout, busy, done, err
    );
endinterface

// File: rtl/memaccess_wait_ctr.sv
// memaccess_wait_ctr: counts wait cycles of one memory access and flags the last allowed one
module memaccess_wait_ctr
    import memaccess_unit_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clock) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    // expired marks the cycle whose increment would reach LIMIT
    assign expired = en && (cnt >= CNT_W'(LIMIT - 1));
endmodule

// File: rtl/memaccess_unit.sv
// memaccess_unit: single read/write/indirect memory access sequencer with per-access timeout
module memaccess_unit
    import memaccess_unit_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int IND_DEPTH = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic             clock,
    input  logic             reset,
    memaccess_unit_if.slave  bus
);
    state_e            state, state_n;
    mem_op_e           op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] memout_q;
    logic [LVL_W-1:0]  lvl;
    logic              err_q;
    logic              expired;
    logic              accept;
    logic              in_access;
    logic              chase;
    assign in_access = state == ST_ACCESS;
    assign accept    = state == ST_IDLE && bus.start && mem_op_e'(bus.mem_state) != OP_NONE;
    assign chase     = op == OP_INDIRECT && lvl != '0;
    memaccess_wait_ctr #(.LIMIT(TIMEOUT)) u_wait (
        .clock   (clock),
        .reset   (reset),
        .clr     (!in_access || bus.dmem_ack),
        .en      (in_access && !bus.dmem_ack),
        .expired (expired)
    );
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   state_n = accept ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_n = bus.dmem_ack ? (chase ? ST_ACCESS : ST_FINISH) :
                                 expired ? ST_FINISH : ST_ACCESS;
            default:   state_n = ST_IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            op       <= OP_READ;
            addr     <= '0;
            data     <= '0;
            memout_q <= '0;
            lvl      <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op    <= mem_op_e'(bus.mem_state);
                addr  <= bus.M_Addr;
                data  <= bus.M_Data;
                lvl   <= LVL_W'(IND_DEPTH);
                err_q <= 1'b0;
            end
            if (in_access && bus.dmem_ack) begin
                if (chase) begin
                    addr <= bus.DMem_dout[ADDR_W-1:0];
                    lvl  <= lvl - 1'b1;
                end else if (op != OP_WRITE) begin
                    memout_q <= bus.DMem_dout;
                end
            end
            if (in_access && !bus.dmem_ack && expired) err_q <= 1'b1;
        end
    end
    assign bus.dmem_en   = in_access;
    assign bus.dmem_we   = in_access && op == OP_WRITE;
    assign bus.dmem_addr = addr;
    assign bus.dmem_din  = data;
    assign bus.memout    = memout_q;
    assign bus.busy      = state != ST_IDLE;
    assign bus.done      = state == ST_FINISH;
    assign bus.err       = state == ST_FINISH && err_q;
endmodule

// File: tb/tb_memaccess_unit.sv
// tb_memaccess_unit: directed and random operations checked against a transaction-level model
module tb_memaccess_unit;
    localparam int IND = 2;
    localparam int TMO = 4;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] memout_model = '0;
    memaccess_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    memaccess_unit #(.ADDR_W(16), .DATA_W(16), .IND_DEPTH(IND), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );
    always #5 clock = ~clock;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'hA5A5) + 16'd7;
    endfunction
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, 32'(bus.dmem_en), 0);
        chk({tag, "_we"}, 32'(bus.dmem_we), 0);
        chk({tag, "_addr"}, 32'(bus.dmem_addr), 0);
        chk({tag, "_din"}, 32'(bus.dmem_din), 0);
        chk({tag, "_memout"}, 32'(bus.memout), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
    endtask
    // Issue one operation; the memory acks each access after w wait cycles.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                          input int w, input bit poke);
        logic [15:0] chain [$];
        logic [15:0] exp_mem;
        int n, exp_done, en_cyc, cyc, idx, wc;
        bit exp_err, seen;
        n = (op == 2'd2) ? IND + 1 : 1;
        chain = {a};
        for (int i = 1; i < n; i++) chain.push_back(rd(chain[i-1]));
        exp_err  = w >= TMO;
        exp_done = exp_err ? 1 + TMO : 1 + n * (w + 1);
        exp_mem  = (exp_err || op == 2'd1) ? memout_model : rd(chain[n-1]);
        bus.start = 1'b1; bus.mem_state = op; bus.M_Addr = a; bus.M_Data = d;
        @(negedge clock);
        bus.start = poke;
        if (poke) begin
            bus.mem_state = 2'd1; bus.M_Addr = ~a; bus.M_Data = ~d;
        end
        cyc = 1; idx = 0; wc = 0; en_cyc = 0; seen = 0;
        while (cyc < 40) begin
            chk("busy", 32'(bus.busy), 1);
            if (bus.done) begin
                seen = 1;
                break;
            end
            bus.dmem_ack = 1'b0;
            if (bus.dmem_en) begin
                en_cyc++;
                chk("addr", 32'(bus.dmem_addr), idx < n ? 32'(chain[idx]) : 32'hFFFF_FFFF);
                chk("we", 32'(bus.dmem_we), 32'(op == 2'd1));
                if (op == 2'd1) chk("din", 32'(bus.dmem_din), 32'(d));
                if (wc == w) begin
                    bus.dmem_ack = 1'b1;
                    bus.DMem_dout = rd(bus.dmem_addr);
                    if (bus.dmem_we) mem[bus.dmem_addr] = bus.dmem_din;
                    idx++;
                    wc = 0;
                end else wc++;
            end
            @(negedge clock);
            bus.start = 1'b0; bus.mem_state = 2'd3;
            cyc++;
        end
        bus.dmem_ack = 1'b0;
        chk("done_seen", 32'(seen), 1);
        chk("latency", 32'(cyc), 32'(exp_done));
        chk("err", 32'(bus.err), 32'(exp_err));
        chk("memout", 32'(bus.memout), 32'(exp_mem));
        chk("en_cycles", 32'(en_cyc), 32'(exp_done - 1));
        @(negedge clock);
        chk("done_pulse", 32'(bus.done), 0);
        chk("idle", 32'(bus.busy), 0);
        memout_model = exp_mem;
    endtask
    initial begin
        bus.start = 1'b0; bus.mem_state = 2'd3; bus.M_Addr = '0; bus.M_Data = '0;
        bus.DMem_dout = '0; bus.dmem_ack = 1'b0;
        repeat (2) @(negedge clock);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        mem[16'h3000] = 16'hBEEF;
        run_op(2'd0, 16'h3000, 16'h0000, 0, 0);
        run_op(2'd1, 16'h4001, 16'h1234, 3, 0);
        mem[16'h0010] = 16'h0020; mem[16'h0020] = 16'h0030; mem[16'h0030] = 16'h5A5A;
        run_op(2'd2, 16'h0010, 16'h0000, 0, 0);
        run_op(2'd0, 16'h3000, 16'h0000, 9, 0);
        run_op(2'd0, 16'h3000, 16'h0000, 3, 0);
        bus.start = 1'b1; bus.mem_state = 2'd2; bus.M_Addr = 16'h0010;
        @(negedge clock);
        bus.start = 1'b0; bus.mem_state = 2'd3;
        @(negedge clock);
        chk("mid_access_en", 32'(bus.dmem_en), 1);
        reset = 1'b1; bus.dmem_ack = 1'b1; bus.DMem_dout = 16'h0020;
        @(negedge clock);
        chk_zero("midreset");
        reset = 1'b0; bus.dmem_ack = 1'b0;
        memout_model = '0;
        @(negedge clock);
        chk("after_reset_done", 32'(bus.done), 0);
        chk("after_reset_busy", 32'(bus.busy), 0);
        run_op(2'd0, 16'h3000, 16'h0000, 1, 0);
        bus.start = 1'b1; bus.mem_state = 2'd3; bus.M_Addr = 16'h3000;
        @(negedge clock);
        bus.start = 1'b0;
        chk("none_busy", 32'(bus.busy), 0);
        chk("none_en", 32'(bus.dmem_en), 0);
        @(negedge clock);
        chk("none_done", 32'(bus.done), 0);
        run_op(2'd0, 16'h3000, 16'h0000, 2, 1);
        run_op(2'd2, 16'h0010, 16'h0000, 1, 1);
        for (int k = 0; k < 40; k++)
            run_op(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), $urandom_range(0, 5), 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
